// File: rtl/picomips_pkg.sv
// ============================================================================
// picomips_pkg : shared types and flag positions for the picoMIPS datapath
// Revision     : 1.0
// ============================================================================
`default_nettype none

package picomips_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mult_state_t;

    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// alu : picoMIPS combinational ALU (pass A/B, add, subtract) with {V,N,Z} flags
// Revision : 1.0
// ============================================================================
`include "alucodes.sv"
`default_nettype none

module alu
    import picomips_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int FUNC_WIDTH = 3,
    parameter int FLAG_WIDTH = 3
) (
    input  logic [BUS_WIDTH-1:0]  a,
    input  logic [BUS_WIDTH-1:0]  b,
    input  logic [FUNC_WIDTH-1:0] func,
    output logic [BUS_WIDTH-1:0]  result,
    output logic [FLAG_WIDTH-1:0] flags
);

    localparam int C_MSB = BUS_WIDTH - 1;

    logic w_ovf;

    always_comb begin
        result = a;
        w_ovf  = 1'b0;
        case (func)
            FUNC_WIDTH'(`RB): result = b;
            FUNC_WIDTH'(`RADD): begin
                result = a + b;
                w_ovf  = (a[C_MSB] == b[C_MSB]) && (result[C_MSB] != a[C_MSB]);
            end
            FUNC_WIDTH'(`RSUB): begin
                result = a - b;
                w_ovf  = (a[C_MSB] != b[C_MSB]) && (result[C_MSB] != a[C_MSB]);
            end
            default: result = a;
        endcase
        flags         = '0;
        flags[FLAG_V] = w_ovf;
        flags[FLAG_N] = result[C_MSB];
        flags[FLAG_Z] = (result == '0);
    end

endmodule

`default_nettype wire

// File: rtl/alucodes.sv
// ============================================================================
// alucodes : picoMIPS ALU function codes shared by the ALU and its controllers
// Revision : 1.0
// ============================================================================
`ifndef ALUCODES_SV
`define ALUCODES_SV
`default_nettype none

`define RA   3'b000
`define RB   3'b001
`define RADD 3'b010
`define RSUB 3'b011

`default_nettype wire
`endif

// File: rtl/alu_booth_mult_seq.sv
// ============================================================================
// alu_booth_mult_seq : sequential radix-2 Booth multiplier driving the shared ALU
// Revision           : 1.0
// ============================================================================
`include "alucodes.sv"
`default_nettype none

module alu_booth_mult_seq
    import picomips_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int FUNC_WIDTH = 3,
    parameter int FLAG_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [BUS_WIDTH-1:0]     mcand,
    input  logic [BUS_WIDTH-1:0]     mplier,
    output logic                     busy,
    output logic                     done,
    output logic [2*BUS_WIDTH-1:0]   product,
    output logic [BUS_WIDTH-1:0]     alu_a,
    output logic [BUS_WIDTH-1:0]     alu_b,
    output logic [FUNC_WIDTH-1:0]    alu_func,
    input  logic [BUS_WIDTH-1:0]     alu_result,
    input  logic [FLAG_WIDTH-1:0]    alu_flags
);

    localparam int               CNT_W  = $clog2(BUS_WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BUS_WIDTH - 1);

    mult_state_t            state_q, state_d;
    logic [BUS_WIDTH-1:0]   acc_q, acc_d;
    logic [BUS_WIDTH-1:0]   q_q, q_d;
    logic                   q_m1_q, q_m1_d;
    logic [BUS_WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*BUS_WIDTH-1:0] product_q, product_d;
    logic                   w_sign;
    logic                   w_unused_z;

    // N^V recovers the sign of the untruncated sum, so M = -2^(W-1) still shifts correctly.
    assign w_sign     = alu_flags[FLAG_N] ^ alu_flags[FLAG_V];
    assign w_unused_z = alu_flags[FLAG_Z];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q_m1_d    = q_m1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_func  = FUNC_WIDTH'(`RA);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    q_d     = mplier;
                    m_d     = mcand;
                    q_m1_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                alu_a = acc_q;
                alu_b = m_q;
                case ({q_q[0], q_m1_q})
                    2'b01:   alu_func = FUNC_WIDTH'(`RADD);
                    2'b10:   alu_func = FUNC_WIDTH'(`RSUB);
                    default: alu_func = FUNC_WIDTH'(`RA);
                endcase
                {acc_d, q_d, q_m1_d} = {w_sign, alu_result, q_q};
                cnt_d = cnt_q + 1'b1;
                // Capture on the final step so product is already valid while done is high.
                if (cnt_q == C_LAST) begin
                    product_d = {w_sign, alu_result, q_q[BUS_WIDTH-1:1]};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q_m1_q    <= q_m1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_booth_mult_seq.sv
// ============================================================================
// tb_alu_booth_mult_seq : checks the Booth multiplier plus ALU against a signed-multiply model
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_alu_booth_mult_seq;

    localparam logic [2:0] C_FUNC_PASS_A = 3'b000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  mcand = 8'h00;
    logic [7:0]  mplier = 8'h00;
    logic        busy, done;
    logic [15:0] product;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_func, alu_flags;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu #(8, 3, 3) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .func   (alu_func),
        .result (alu_result),
        .flags  (alu_flags)
    );

    alu_booth_mult_seq #(.BUS_WIDTH(8), .FUNC_WIDTH(3), .FLAG_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mcand      (mcand),
        .mplier     (mplier),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int pa, pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return 16'(pa * pb);
    endfunction

    // Called at a negedge in IDLE; returns at the negedge where done is seen (or timeout).
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                            output logic [15:0] p, output int edges, output bit ok);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        edges  = 0;
        ok     = 1'b0;
        while (edges < 40 && !ok) begin
            @(negedge clk);
            edges++;
            start = 1'b0;
            if (done) ok = 1'b1;
        end
        p = product;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 ||
            alu_a !== 8'h00 || alu_b !== 8'h00 || alu_func !== C_FUNC_PASS_A) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b product=%h a=%h b=%h func=%b, required 0 0 0000 00 00 000",
                     busy, done, product, alu_a, alu_b, alu_func);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] ta [7] = '{8'd3, 8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h7F};
        logic [7:0] tb [7] = '{8'd5, 8'h80, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'h7F};
        logic [15:0] want [7] = '{16'h000F, 16'h4000, 16'hC080, 16'h3F01, 16'h0000, 16'h0001, 16'h3F01};
        logic [15:0] p;
        int edges;
        bit ok;
        for (int i = 0; i < 7; i++) begin
            run_mult(ta[i], tb[i], p, edges, ok);
            vectors++;
            if (!ok || p !== want[i]) begin
                miscompares++;
                $display("FAIL directed[%0d] %h*%h: done=%b product=%h, required %h", i, ta[i], tb[i], ok, p, want[i]);
            end
            if (i == 0) begin
                vectors++;
                if (edges !== 9) begin
                    miscompares++;
                    $display("FAIL latency: done after %0d edges, required 9", edges);
                end
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL done_width[%0d]: done=%b busy=%b after pulse, required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] want;
        int seen;
        want   = model(8'd7, 8'hF7);
        mcand  = 8'd7;
        mplier = 8'hF7;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        mcand  = 8'd55;
        mplier = 8'd66;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        while (!done && seen < 30) begin
            @(negedge clk);
            seen++;
        end
        vectors++;
        if (!done || product !== want) begin
            miscompares++;
            $display("FAIL ignore_run: done=%b product=%h, required 1 %h", done, product, want);
        end
        mcand  = 8'd99;
        mplier = 8'd11;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        vectors++;
        if (seen !== 0 || product !== want) begin
            miscompares++;
            $display("FAIL ignore_done: extra activity=%0d product=%h, required 0 %h", seen, product, want);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p;
        int edges;
        bit ok;
        mcand  = 8'd100;
        mplier = 8'hC3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || alu_func !== C_FUNC_PASS_A) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b done=%b product=%h func=%b, required 0 0 0000 000",
                     busy, done, product, alu_func);
        end
        reset = 1'b0;
        @(negedge clk);
        run_mult(8'hE5, 8'd19, p, edges, ok);
        vectors++;
        if (!ok || p !== model(8'hE5, 8'd19)) begin
            miscompares++;
            $display("FAIL after_reset: done=%b product=%h, required %h", ok, p, model(8'hE5, 8'd19));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back(input int n);
        logic [7:0] corners [5] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};
        logic [15:0] exp_q [$];
        logic [7:0] a, b;
        int last_done, waited;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(model(a, b));
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        last_done = -1;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!done && waited < 30);
            vectors++;
            if (!done) begin
                miscompares++;
                $display("FAIL b2b_timeout[%0d]: no done within 30 cycles", i);
                break;
            end
            if (product !== exp_q[0]) begin
                miscompares++;
                $display("FAIL b2b[%0d] %h*%h: product=%h, required %h", i, mcand, mplier, product, exp_q[0]);
            end
            void'(exp_q.pop_front());
            if (last_done >= 0) begin
                vectors++;
                if (cyc - last_done !== 10) begin
                    miscompares++;
                    $display("FAIL interval[%0d]: %0d cycles, required 10", i, cyc - last_done);
                end
            end
            last_done = cyc;
            a = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : 8'($urandom_range(0, 255));
            mcand  = a;
            mplier = b;
            exp_q.push_back(model(a, b));
            if (i == n - 1) start = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
